// File: rtl/dma_w_feeder_if.sv
// dma_w_feeder_if: control, source-stream and write-engine handshake bundle for dma_w_feeder
//   control : start, start_addr, total_words -> busy, done, err
//   source  : s_valid, s_data -> s_ready
//   engine  : valid, addr, wdata, wstrb, dma_len -> ready, dma_ready, error
//   slave is the feeder's view, master is the view of whatever drives it
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
interface dma_w_feeder_if #(
  parameter int DMA_DATA_W = 32,
  parameter int ADDR_W = `AXI_ADDR_W
);
  logic start;
  logic [ADDR_W-1:0] start_addr;
  logic [15:0] total_words;
  logic busy;
  logic done;
  logic err;
  logic s_valid;
  logic [DMA_DATA_W-1:0] s_data;
  logic s_ready;
  logic valid;
  logic [ADDR_W-1:0] addr;
  logic [DMA_DATA_W-1:0] wdata;
  logic [DMA_DATA_W/8-1:0] wstrb;
  logic ready;
  logic [`AXI_LEN_W-1:0] dma_len;
  logic dma_ready;
  logic error;
  modport slave (
    input start, start_addr, total_words, s_valid, s_data, ready, dma_ready, error,
    output busy, done, err, s_ready, valid, addr, wdata, wstrb, dma_len
  );
  modport master (
    output start, start_addr, total_words, s_valid, s_data, ready, dma_ready, error,
    input busy, done, err, s_ready, valid, addr, wdata, wstrb, dma_len
  );
endinterface

// File: rtl/dma_w_feeder.sv
// dma_w_feeder: buffers a source word stream in a FIFO and feeds it to a write engine as bursts
//   clk, rst : clock and asynchronous active-high reset
//   bus      : dma_w_feeder_if.slave carrying control, source stream and write-engine signals
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
module dma_w_feeder #(
  parameter int DMA_DATA_W = 32,
  parameter int ADDR_W = `AXI_ADDR_W,
  parameter int FIFO_ADDR_W = 4,
  parameter int MAX_BURST = 16
) (
  input logic clk,
  input logic rst,
  dma_w_feeder_if.slave bus
);
  localparam int DEPTH = 2 ** FIFO_ADDR_W;
  localparam int CW = FIFO_ADDR_W + 1;
  localparam int LEN_W = `AXI_LEN_W;
  typedef enum logic [1:0] {IDLE, FILL, BURST, WAIT_RESP} state_t;
  state_t state;
  logic [DMA_DATA_W-1:0] mem [DEPTH];
  logic [FIFO_ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [15:0] total, accepted, remaining, beats, left, beats_n;
  logic push, pop;
  assign beats_n = remaining < 16'(MAX_BURST) ? remaining : 16'(MAX_BURST);
  // accepted caps intake so words belonging to no transfer never enter the FIFO
  assign bus.s_ready = bus.busy && count != CW'(DEPTH) && accepted < total;
  assign push = bus.s_valid && bus.s_ready;
  assign pop = bus.valid && bus.ready;
  assign bus.wdata = mem[rd_ptr];
  assign bus.wstrb = '1;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= bus.s_data;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      total <= '0;
      accepted <= '0;
      remaining <= '0;
      beats <= '0;
      left <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.err <= 1'b0;
      bus.valid <= 1'b0;
      bus.addr <= '0;
      bus.dma_len <= '0;
    end else begin
      bus.done <= 1'b0;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        accepted <= accepted + 16'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      case (state)
        IDLE:
          if (bus.start) begin
            if (bus.total_words != 16'd0) begin
              bus.addr <= bus.start_addr;
              total <= bus.total_words;
              remaining <= bus.total_words;
              accepted <= '0;
              bus.busy <= 1'b1;
              bus.err <= 1'b0;
              state <= FILL;
            end else bus.done <= 1'b1;
          end
        // a burst is only issued once every beat of it is already buffered, so it cannot underflow
        FILL:
          if (16'(count) >= beats_n && bus.dma_ready) begin
            beats <= beats_n;
            left <= beats_n;
            bus.dma_len <= LEN_W'(beats_n - 16'd1);
            bus.valid <= 1'b1;
            state <= BURST;
          end
        BURST:
          if (pop) begin
            left <= left - 16'd1;
            if (left == 16'd1) begin
              bus.valid <= 1'b0;
              state <= WAIT_RESP;
            end
          end
        WAIT_RESP:
          if (bus.dma_ready) begin
            bus.err <= bus.err | bus.error;
            remaining <= remaining - beats;
            bus.addr <= bus.addr + ADDR_W'(32'(beats) * (DMA_DATA_W / 8));
            if (remaining == beats) begin
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              state <= IDLE;
            end else state <= FILL;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
